dram_cmd_scheduler: RTL
=======================

# dram_cmd_scheduler

Command scheduler between the controller's decoded request path and the DRAM command interface. It accepts one translated request at a time (bank, row, column, read/write) and tracks the open row of every bank. It issues the minimal PRECHARGE/ACTIVATE/READ/WRITE sequence over a req/ack command handshake. It also owns the periodic refresh timer, and refresh takes priority over new requests.

## Interface
Parameters:
- NUM_OF_BANKS, 8, bank count; BW = $clog2(NUM_OF_BANKS)
- NUM_OF_ROWS, 128, rows per bank; RW_W = $clog2(NUM_OF_ROWS)
- NUM_OF_COLS, 8, columns per row; CW = $clog2(NUM_OF_COLS)
- REF_INTERVAL, 1024, cycles between refresh requests (≥ 16)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  scheduler accepts request this cycle
- req_rw  in  1  1 = write, 0 = read
- req_bank  in  BW  target bank
- req_row  in  RW_W  target row
- req_col  in  CW  target column
- cmd_req  out  1  command valid toward DRAM
- cmd_ack  in  1  DRAM accepted command
- cmd  out  3  command code (see Structure)
- cmd_bank  out  BW  command bank
- cmd_row  out  RW_W  command row (ACT only, else 0)
- cmd_col  out  CW  command column (RD/WR only, else 0)
- done_valid  out  1  one-cycle pulse: RD/WR completed
- done_rw  out  1  rw of completed access, valid with done_valid
- refresh_pending  out  1  refresh owed
- ref_overrun  out  1  sticky: interval expired while refresh still pending

## Operation
- FSM states: IDLE, PRE, ACT, ACCESS, PREA, REF.
- IDLE:
  - if refresh_pending: go to PREA if any bank is open, else REF; no request accepted.
  - else req_ready=1; on req_valid, latch the request and branch:
    - bank open, same row → ACCESS
    - bank open, different row → PRE
    - bank closed → ACT
- Command states drive cmd_req=1 with stable cmd/bank/row/col. Completion is the edge where cmd_req&&cmd_ack.
  - PRE → ACT
  - ACT → ACCESS
  - ACCESS → IDLE
  - PREA → REF
  - REF → IDLE
- Without ack, remain in the state with outputs unchanged.
- Open-row table, per bank {open, row}, updated on completion:
  - ACT sets open=1 and row
  - PRE clears the bank
  - PREA clears all banks
  - RD/WR and REF leave the table unchanged
- Refresh timer:
  - counts 0..REF_INTERVAL-1 and wraps; sets refresh_pending at wrap
  - REF completion clears refresh_pending
  - a wrap while pending is still set sets ref_overrun (cleared only by rst); pending stays 1, not double-counted
  - counting continues in all states
- A REF completion in the same cycle as a wrap leaves pending = 1 (set wins).
- req_ready = (state==IDLE) && !refresh_pending, combinational.
- Reset mid-sequence: immediate return to IDLE, table cleared, counter 0, in-flight request dropped, no done pulse.

## Timing
- Reset values:
  - cmd_req=0, cmd=NOP, cmd_bank/row/col=0
  - done_valid=0, done_rw=0, refresh_pending=0, ref_overrun=0
  - req_ready=1 (IDLE, nothing pending)
- With cmd_ack tied high, request accepted at edge N:
  - row hit: RD/WR cmd_req in cycle N+1; done_valid in N+2; req_ready again in N+2
  - bank closed: ACT in N+1, RD/WR in N+2, done in N+3
  - row conflict: PRE in N+1, ACT in N+2, RD/WR in N+3, done in N+4
- Each cycle cmd_ack is withheld adds one cycle to the state.
- cmd_req stays high across back-to-back command states; the code changes on the edge after ack.
- done_valid is registered: high exactly one cycle after the ACCESS ack edge.
- cmd_ack while cmd_req=0 is ignored.

## Structure
- Shared header dram_sched_defs.vh, with localparams:
  - command codes: NOP=3'd0, ACT=3'd1, RD=3'd2, WR=3'd3, PRE=3'd4, PREA=3'd5, REF=3'd6
  - FSM state encodings
- Sub-module dram_refresh_timer holds the interval counter and the pending/overrun flags. Inputs: clk, rst, ref_done. Outputs: refresh_pending, ref_overrun.
- The open-row table and FSM stay in the top module.

## Test plan
- Reset, then read bank 2 row 5 col 3 with ack tied high → ACT(b2, r5), then RD(b2, c3); done_valid at N+3, done_rw=0.
- Write bank 2 row 5 col 7 again → WR only; done at N+2.
- Read bank 2 row 9 → PRE(b2), ACT(b2, r9), RD; done at N+4; bank 2 table row = 9.
- Hold cmd_ack low 5 cycles during ACT → cmd/cmd_row stable throughout, no state advance; done delayed by 5 cycles.
- REF_INTERVAL=16 with bank 1 open and a request waiting → at wrap, req_ready=0, PREA then REF issued; pending clears; request accepted afterward and takes the ACT path (bank closed).
- Refresh pending with cmd_ack held low past a second wrap → ref_overrun=1 stays set. Assert rst mid-PRE → all outputs return to reset values and no done pulse.

Source files
------------

// File: rtl/dram_cmd_scheduler_pkg.sv
// Shared command codes and FSM state encoding for the DRAM command scheduler.
package dram_cmd_scheduler_pkg;

    localparam int unsigned CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_NOP  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_ACT  = 3'd1;
    localparam logic [CMD_W-1:0] CMD_RD   = 3'd2;
    localparam logic [CMD_W-1:0] CMD_WR   = 3'd3;
    localparam logic [CMD_W-1:0] CMD_PRE  = 3'd4;
    localparam logic [CMD_W-1:0] CMD_PREA = 3'd5;
    localparam logic [CMD_W-1:0] CMD_REF  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_ACT    = 3'd2,
        ST_ACCESS = 3'd3,
        ST_PREA   = 3'd4,
        ST_REF    = 3'd5
    } state_t;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with pending and sticky overrun flags.
module dram_refresh_timer #(
    parameter int unsigned REF_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_done,
    output logic refresh_pending,
    output logic ref_overrun
);

    localparam int unsigned CNT_W = $clog2(REF_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_overrun;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);

    // A wrap always wins over a same-cycle refresh completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            if (w_wrap) begin
                r_pending <= 1'b1;
            end else if (ref_done) begin
                r_pending <= 1'b0;
            end
            if (w_wrap && r_pending) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign refresh_pending = r_pending;
    assign ref_overrun     = r_overrun;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Open-row-aware DRAM command scheduler: issues PRE/ACT/RD/WR per request and PREA/REF on refresh.
module dram_cmd_scheduler
    import dram_cmd_scheduler_pkg::*;
#(
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned NUM_OF_ROWS  = 128,
    parameter int unsigned NUM_OF_COLS  = 8,
    parameter int unsigned REF_INTERVAL = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_rw,
    input  logic [$clog2(NUM_OF_BANKS)-1:0]  req_bank,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]   req_row,
    input  logic [$clog2(NUM_OF_COLS)-1:0]   req_col,
    output logic                             cmd_req,
    input  logic                             cmd_ack,
    output logic [2:0]                       cmd,
    output logic [$clog2(NUM_OF_BANKS)-1:0]  cmd_bank,
    output logic [$clog2(NUM_OF_ROWS)-1:0]   cmd_row,
    output logic [$clog2(NUM_OF_COLS)-1:0]   cmd_col,
    output logic                             done_valid,
    output logic                             done_rw,
    output logic                             refresh_pending,
    output logic                             ref_overrun
);

    localparam int unsigned BW   = $clog2(NUM_OF_BANKS);
    localparam int unsigned RW_W = $clog2(NUM_OF_ROWS);
    localparam int unsigned CW   = $clog2(NUM_OF_COLS);

    state_t r_state, w_state_nxt;

    logic                                r_req_rw;
    logic [BW-1:0]                       r_req_bank;
    logic [RW_W-1:0]                     r_req_row;
    logic [CW-1:0]                       r_req_col;
    logic [NUM_OF_BANKS-1:0]             r_open;
    logic [NUM_OF_BANKS-1:0][RW_W-1:0]   r_open_row;

    logic                r_cmd_req;
    logic [CMD_W-1:0]    r_cmd;
    logic [BW-1:0]       r_cmd_bank;
    logic [RW_W-1:0]     r_cmd_row;
    logic [CW-1:0]       r_cmd_col;
    logic                r_done_valid;
    logic                r_done_rw;

    logic                w_accept;
    logic                w_cmd_done;
    logic                w_ref_done;
    logic                w_ref_pending;
    logic                w_req_rw_nxt;
    logic [BW-1:0]       w_req_bank_nxt;
    logic [RW_W-1:0]     w_req_row_nxt;
    logic [CW-1:0]       w_req_col_nxt;
    logic                w_cmd_req_nxt;
    logic [CMD_W-1:0]    w_cmd_nxt;
    logic [BW-1:0]       w_cmd_bank_nxt;
    logic [RW_W-1:0]     w_cmd_row_nxt;
    logic [CW-1:0]       w_cmd_col_nxt;

    assign w_cmd_done = r_cmd_req && cmd_ack;
    assign w_ref_done = (r_state == ST_REF) && w_cmd_done;

    dram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh_timer (
        .clk             (clk),
        .rst             (rst),
        .ref_done        (w_ref_done),
        .refresh_pending (w_ref_pending),
        .ref_overrun     (ref_overrun)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, then the command bundle to present in that state so outputs come from flops.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_cmd_req_nxt  = 1'b0;
        w_cmd_nxt      = CMD_NOP;
        w_cmd_bank_nxt = '0;
        w_cmd_row_nxt  = '0;
        w_cmd_col_nxt  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_ref_pending) begin
                    w_state_nxt = (|r_open) ? ST_PREA : ST_REF;
                end else if (req_valid) begin
                    w_accept = 1'b1;
                    if (!r_open[req_bank]) begin
                        w_state_nxt = ST_ACT;
                    end else if (r_open_row[req_bank] == req_row) begin
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_PRE;
                    end
                end
            end
            ST_PRE:    if (w_cmd_done) w_state_nxt = ST_ACT;
            ST_ACT:    if (w_cmd_done) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_cmd_done) w_state_nxt = ST_IDLE;
            ST_PREA:   if (w_cmd_done) w_state_nxt = ST_REF;
            ST_REF:    if (w_cmd_done) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_req_rw_nxt   = w_accept ? req_rw   : r_req_rw;
        w_req_bank_nxt = w_accept ? req_bank : r_req_bank;
        w_req_row_nxt  = w_accept ? req_row  : r_req_row;
        w_req_col_nxt  = w_accept ? req_col  : r_req_col;

        case (w_state_nxt)
            ST_PRE: begin
                w_cmd_req_nxt  = 1'b1;
                w_cmd_nxt      = CMD_PRE;
                w_cmd_bank_nxt = w_req_bank_nxt;
            end
            ST_ACT: begin
                w_cmd_req_nxt  = 1'b1;
                w_cmd_nxt      = CMD_ACT;
                w_cmd_bank_nxt = w_req_bank_nxt;
                w_cmd_row_nxt  = w_req_row_nxt;
            end
            ST_ACCESS: begin
                w_cmd_req_nxt  = 1'b1;
                w_cmd_nxt      = w_req_rw_nxt ? CMD_WR : CMD_RD;
                w_cmd_bank_nxt = w_req_bank_nxt;
                w_cmd_col_nxt  = w_req_col_nxt;
            end
            ST_PREA: begin
                w_cmd_req_nxt = 1'b1;
                w_cmd_nxt     = CMD_PREA;
            end
            ST_REF: begin
                w_cmd_req_nxt = 1'b1;
                w_cmd_nxt     = CMD_REF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_rw     <= 1'b0;
            r_req_bank   <= '0;
            r_req_row    <= '0;
            r_req_col    <= '0;
            r_cmd_req    <= 1'b0;
            r_cmd        <= CMD_NOP;
            r_cmd_bank   <= '0;
            r_cmd_row    <= '0;
            r_cmd_col    <= '0;
            r_done_valid <= 1'b0;
            r_done_rw    <= 1'b0;
        end else begin
            r_req_rw     <= w_req_rw_nxt;
            r_req_bank   <= w_req_bank_nxt;
            r_req_row    <= w_req_row_nxt;
            r_req_col    <= w_req_col_nxt;
            r_cmd_req    <= w_cmd_req_nxt;
            r_cmd        <= w_cmd_nxt;
            r_cmd_bank   <= w_cmd_bank_nxt;
            r_cmd_row    <= w_cmd_row_nxt;
            r_cmd_col    <= w_cmd_col_nxt;
            r_done_valid <= (r_state == ST_ACCESS) && w_cmd_done;
            if ((r_state == ST_ACCESS) && w_cmd_done) begin
                r_done_rw <= r_req_rw;
            end
        end
    end

    // Open-row table follows completed ACT/PRE/PREA commands only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open     <= '0;
            r_open_row <= '0;
        end else if (w_cmd_done) begin
            case (r_state)
                ST_ACT: begin
                    r_open[r_req_bank]     <= 1'b1;
                    r_open_row[r_req_bank] <= r_req_row;
                end
                ST_PRE: begin
                    r_open[r_req_bank]     <= 1'b0;
                    r_open_row[r_req_bank] <= '0;
                end
                ST_PREA: begin
                    r_open     <= '0;
                    r_open_row <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready       = (r_state == ST_IDLE) && !w_ref_pending;
    assign cmd_req         = r_cmd_req;
    assign cmd             = r_cmd;
    assign cmd_bank        = r_cmd_bank;
    assign cmd_row         = r_cmd_row;
    assign cmd_col         = r_cmd_col;
    assign done_valid      = r_done_valid;
    assign done_rw         = r_done_rw;
    assign refresh_pending = w_ref_pending;

endmodule
